// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state encodings for serial_add_ctrl
package serial_add_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// serial_add_ctrl_fa_bit: 1-bit full adder (fa_bit) built from two half adders (ha_rtl)
module ha_rtl (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module fa_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic s1, c1, c2;
  ha_rtl u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s1), .c_o(c1));
  ha_rtl u_ha1 (.a_i(s1), .b_i(c_i), .s_o(s_o), .c_o(c2));
  assign c_o = c1 | c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial a+b+cin adder, LSB first; ovf port exists only with SERIAL_ADD_OVF_EN
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, busy_q, done_q, cout_q, ovf_q;
  logic             s_bit, c_bit;
  logic [WIDTH-1:0] res_d;
  fa_bit u_fa (.a_i(a_q[0]), .b_i(b_q[0]), .c_i(c_q), .s_o(s_bit), .c_o(c_bit));
  assign res_d = {s_bit, res_q[WIDTH-1:1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          res_q <= res_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_bit;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            sum_q   <= res_d;
            cout_q  <= c_bit;
            ovf_q   <= c_q ^ c_bit;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation, giving back-to-back starts
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif
endmodule
